// File: rtl/decode_stage.sv
// RV64IM decode stage: decodes in_instr_i into a machine-readable record and
// queues it in a 2-entry buffer with valid/ready on both sides.
module decode_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_instr_i,
    input  logic [XLEN-1:0]  in_pc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_pc_o,
    output logic [3:0]       out_class_o,
    output logic [4:0]       out_rd_o,
    output logic [4:0]       out_rs1_o,
    output logic [4:0]       out_rs2_o,
    output logic [2:0]       out_funct3_o,
    output logic [6:0]       out_funct7_o,
    output logic [XLEN-1:0]  out_imm_o,
    output logic             out_word_o,
    output logic             out_illegal_o,
    output logic [CNT_W-1:0] illegal_count_o
);
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [3:0]      cls;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic            word;
        logic            illegal;
    } rec_t;

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [5:0]      top6;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    rec_t            dec;
    logic            bad;

    assign opc   = in_instr_i[6:0];
    assign f3    = in_instr_i[14:12];
    assign f7    = in_instr_i[31:25];
    assign top6  = in_instr_i[31:26];
    assign imm_i = XLEN'($signed(in_instr_i[31:20]));
    assign imm_s = XLEN'($signed({in_instr_i[31:25], in_instr_i[11:7]}));
    assign imm_b = XLEN'($signed({in_instr_i[31], in_instr_i[7], in_instr_i[30:25],
                                  in_instr_i[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_instr_i[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_instr_i[31], in_instr_i[19:12], in_instr_i[20],
                                  in_instr_i[30:21], 1'b0}));

    always_comb begin
        dec     = '0;
        dec.pc  = in_pc_i;
        bad     = 1'b0;
        case (opc)
            OPC_OP, OPC_OP32: begin
                dec.cls    = 4'd0;
                dec.rd     = in_instr_i[11:7];
                dec.rs1    = in_instr_i[19:15];
                dec.rs2    = in_instr_i[24:20];
                dec.funct3 = f3;
                dec.funct7 = f7;
                dec.word   = (opc == OPC_OP32);
                if (f7 != 7'b0000000 && f7 != 7'b0100000 && f7 != 7'b0000001) bad = 1'b1;
                if (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101) bad = 1'b1;
                if (opc == OPC_OP32 && (f3 == 3'b010 || f3 == 3'b011 || XLEN == 32)) bad = 1'b1;
            end
            OPC_OPIMM, OPC_OPIMM32: begin
                dec.cls    = 4'd1;
                dec.rd     = in_instr_i[11:7];
                dec.rs1    = in_instr_i[19:15];
                dec.funct3 = f3;
                dec.imm    = imm_i;
                dec.word   = (opc == OPC_OPIMM32);
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    // shifts carry the shamt in imm and the shift-type bits in funct7
                    dec.funct7 = {top6, 1'b0};
                    if (top6 != 6'b000000 && !(f3 == 3'b101 && top6 == 6'b010000)) bad = 1'b1;
                    if (opc == OPC_OPIMM32) begin
                        dec.imm = XLEN'(in_instr_i[24:20]);
                        if (in_instr_i[25]) bad = 1'b1;
                    end else begin
                        dec.imm = XLEN'(in_instr_i[25:20]);
                        if (XLEN == 32 && in_instr_i[25]) bad = 1'b1;
                    end
                end else if (opc == OPC_OPIMM32 && f3 != 3'b000) begin
                    bad = 1'b1;
                end
                if (opc == OPC_OPIMM32 && XLEN == 32) bad = 1'b1;
            end
            OPC_LOAD: begin
                dec.cls    = 4'd2;
                dec.rd     = in_instr_i[11:7];
                dec.rs1    = in_instr_i[19:15];
                dec.funct3 = f3;
                dec.imm    = imm_i;
                if (f3 == 3'b111) bad = 1'b1;
            end
            OPC_STORE: begin
                dec.cls    = 4'd3;
                dec.rs1    = in_instr_i[19:15];
                dec.rs2    = in_instr_i[24:20];
                dec.funct3 = f3;
                dec.imm    = imm_s;
                if (f3[2]) bad = 1'b1;
            end
            OPC_BRANCH: begin
                dec.cls    = 4'd4;
                dec.rs1    = in_instr_i[19:15];
                dec.rs2    = in_instr_i[24:20];
                dec.funct3 = f3;
                dec.imm    = imm_b;
                if (f3[2:1] == 2'b01) bad = 1'b1;
            end
            OPC_JAL: begin
                dec.cls = 4'd5;
                dec.rd  = in_instr_i[11:7];
                dec.imm = imm_j;
            end
            OPC_JALR: begin
                dec.cls    = 4'd6;
                dec.rd     = in_instr_i[11:7];
                dec.rs1    = in_instr_i[19:15];
                dec.funct3 = f3;
                dec.imm    = imm_i;
                if (f3 != 3'b000) bad = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.cls = (opc == OPC_LUI) ? 4'd7 : 4'd8;
                dec.rd  = in_instr_i[11:7];
                dec.imm = imm_u;
            end
            default: bad = 1'b1;
        endcase
        if (in_instr_i[1:0] != 2'b11) bad = 1'b1;
        if (bad) begin
            dec         = '0;
            dec.pc      = in_pc_i;
            dec.cls     = 4'd15;
            dec.illegal = 1'b1;
        end
    end

    // Entry 0 is always the head; entry 1 only holds data when count is 2.
    rec_t             ent_q [2];
    rec_t             ent_d [2];
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
    logic             push, pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign push        = in_valid_i & in_ready_o & ~flush_i;
    assign pop         = out_valid_o & out_ready_i & ~flush_i;

    always_comb begin
        ent_d     = ent_q;
        count_d   = count_q;
        ill_cnt_d = ill_cnt_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            if (pop) ent_d[0] = ent_q[1];
            if (push) begin
                if (count_q == 2'd0 || pop) ent_d[0] = dec;
                else                        ent_d[1] = dec;
            end
            count_d = count_q + 2'(push) - 2'(pop);
            if (push && dec.illegal && ill_cnt_q != '1) ill_cnt_d = ill_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ent_q[0]  <= '0;
            ent_q[1]  <= '0;
            count_q   <= 2'd0;
            ill_cnt_q <= '0;
        end else begin
            ent_q[0]  <= ent_d[0];
            ent_q[1]  <= ent_d[1];
            count_q   <= count_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign out_pc_o        = ent_q[0].pc;
    assign out_class_o     = ent_q[0].cls;
    assign out_rd_o        = ent_q[0].rd;
    assign out_rs1_o       = ent_q[0].rs1;
    assign out_rs2_o       = ent_q[0].rs2;
    assign out_funct3_o    = ent_q[0].funct3;
    assign out_funct7_o    = ent_q[0].funct7;
    assign out_imm_o       = ent_q[0].imm;
    assign out_word_o      = ent_q[0].word;
    assign out_illegal_o   = ent_q[0].illegal;
    assign illegal_count_o = ill_cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vectors plus random traffic checked against
// an arithmetic decode model and a queue model of the 2-entry buffer.
module tb_decode_stage;
    typedef struct packed {
        logic [63:0] pc;
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic        word;
        logic        ill;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        in_ready, out_valid, out_word, out_illegal;
    logic [63:0] out_pc, out_imm;
    logic [3:0]  out_class;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [15:0] illegal_count;
    logic        s_in_ready, s_out_valid, s_out_word, s_out_illegal;
    logic [63:0] s_out_pc, s_out_imm;
    logic [3:0]  s_out_class;
    logic [4:0]  s_out_rd, s_out_rs1, s_out_rs2;
    logic [2:0]  s_out_funct3;
    logic [6:0]  s_out_funct7;
    logic [1:0]  s_illegal_count;
    rec_t        obs, s_obs;

    int   total = 0;
    int   bad = 0;
    rec_t mq[$];
    int   ill_total = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(64), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_instr_i(in_instr), .in_pc_i(in_pc), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_pc_o(out_pc), .out_class_o(out_class), .out_rd_o(out_rd), .out_rs1_o(out_rs1),
        .out_rs2_o(out_rs2), .out_funct3_o(out_funct3), .out_funct7_o(out_funct7),
        .out_imm_o(out_imm), .out_word_o(out_word), .out_illegal_o(out_illegal),
        .illegal_count_o(illegal_count));

    decode_stage #(.XLEN(64), .CNT_W(2)) u_sat (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
        .in_instr_i(in_instr), .in_pc_i(in_pc), .out_valid_o(s_out_valid), .out_ready_i(out_ready),
        .out_pc_o(s_out_pc), .out_class_o(s_out_class), .out_rd_o(s_out_rd), .out_rs1_o(s_out_rs1),
        .out_rs2_o(s_out_rs2), .out_funct3_o(s_out_funct3), .out_funct7_o(s_out_funct7),
        .out_imm_o(s_out_imm), .out_word_o(s_out_word), .out_illegal_o(s_out_illegal),
        .illegal_count_o(s_illegal_count));

    assign obs   = {out_pc, out_class, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
                    out_imm, out_word, out_illegal};
    assign s_obs = {s_out_pc, s_out_class, s_out_rd, s_out_rs1, s_out_rs2, s_out_funct3,
                    s_out_funct7, s_out_imm, s_out_word, s_out_illegal};

    // Decode reference: format letter from the opcode, immediates by signed arithmetic.
    function automatic rec_t model(input logic [31:0] ins, input logic [63:0] pc);
        rec_t   r;
        byte    fmt;
        bit     bad_enc, shift;
        int     f3, f7, top6;
        longint s;
        r = '0; bad_enc = 0; fmt = "X";
        f3 = int'(ins[14:12]); f7 = int'(ins[31:25]); top6 = int'(ins[31:26]);
        s = longint'($signed(ins));
        case (ins[6:0])
            7'h33: begin fmt = "R"; r.cls = 0; end
            7'h3B: begin fmt = "R"; r.cls = 0; r.word = 1; end
            7'h13: begin fmt = "I"; r.cls = 1; end
            7'h1B: begin fmt = "I"; r.cls = 1; r.word = 1; end
            7'h03: begin fmt = "I"; r.cls = 2; bad_enc = (f3 == 7); end
            7'h23: begin fmt = "S"; r.cls = 3; bad_enc = (f3 >= 4); end
            7'h63: begin fmt = "B"; r.cls = 4; bad_enc = (f3 == 2 || f3 == 3); end
            7'h6F: begin fmt = "J"; r.cls = 5; end
            7'h67: begin fmt = "I"; r.cls = 6; bad_enc = (f3 != 0); end
            7'h37: begin fmt = "U"; r.cls = 7; end
            7'h17: begin fmt = "U"; r.cls = 8; end
            default: bad_enc = 1;
        endcase
        if (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J") r.rd = ins[11:7];
        if (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B") begin
            r.rs1 = ins[19:15];
            r.f3  = ins[14:12];
        end
        if (fmt == "R" || fmt == "S" || fmt == "B") r.rs2 = ins[24:20];
        if (fmt == "I") r.imm = 64'(s >>> 20);
        if (fmt == "S") r.imm = 64'(((s >>> 25) <<< 5) | longint'(ins[11:7]));
        if (fmt == "B") r.imm = 64'(((s >>> 31) <<< 12) | (longint'(ins[7]) << 11)
                                    | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1));
        if (fmt == "U") r.imm = 64'((s >>> 12) <<< 12);
        if (fmt == "J") r.imm = 64'(((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
                                    | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1));
        if (fmt == "R") begin
            r.f7 = ins[31:25];
            if (!(f7 == 0 || f7 == 32 || f7 == 1)) bad_enc = 1;
            if (f7 == 32 && f3 != 0 && f3 != 5) bad_enc = 1;
            if (r.word && (f3 == 2 || f3 == 3)) bad_enc = 1;
        end
        if (r.cls == 1 && fmt == "I") begin
            shift = (f3 == 1 || f3 == 5);
            if (r.word && !(f3 == 0 || shift)) bad_enc = 1;
            if (shift) begin
                r.f7  = 7'(top6 * 2);
                r.imm = r.word ? 64'(ins[24:20]) : 64'(ins[25:20]);
                if (top6 != 0 && !(f3 == 5 && top6 == 16)) bad_enc = 1;
                if (r.word && ins[25]) bad_enc = 1;
            end
        end
        if (ins[1:0] != 2'b11) bad_enc = 1;
        if (bad_enc) begin
            r = '0; r.cls = 15; r.ill = 1;
        end
        r.pc = pc;
        return r;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 12))
            0: w[6:0] = 7'h33;   1: w[6:0] = 7'h3B;   2: w[6:0] = 7'h13;
            3: w[6:0] = 7'h1B;   4: w[6:0] = 7'h03;   5: w[6:0] = 7'h23;
            6: w[6:0] = 7'h63;   7: w[6:0] = 7'h6F;   8: w[6:0] = 7'h67;
            9: w[6:0] = 7'h37;  10: w[6:0] = 7'h17;
            default: ;
        endcase
        if (w[6:0] == 7'h33 || w[6:0] == 7'h3B) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;  1: w[31:25] = 7'h20;  2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        if ((w[6:0] == 7'h13 || w[6:0] == 7'h1B) && (w[14:12] == 3'd1 || w[14:12] == 3'd5)) begin
            case ($urandom_range(0, 2))
                0: w[31:26] = 6'd0;  1: w[31:26] = 6'd16;
                default: ;
            endcase
        end
        return w;
    endfunction

    // Advance one clock and move the buffer model the same way.
    task automatic tick();
        bit   push, pop;
        rec_t r;
        push = in_valid && (mq.size() < 2) && !flush;
        pop  = (mq.size() > 0) && out_ready && !flush;
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                r = model(in_instr, in_pc);
                mq.push_back(r);
                if (r.ill) ill_total++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_ctrl valid=%b ready=%b cnt=%0d want 0/1/0", out_valid, in_ready, illegal_count);
        end
        total++;
        if (obs !== '0 || s_obs !== '0) begin
            bad++;
            $display("FAIL reset_data got=%h sat=%h want 0", obs, s_obs);
        end
        rst = 1'b0;
        mq.delete();
        ill_total = 0;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release ready=%b valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ins_t [4];
        logic [3:0]  cls_t [4];
        logic [4:0]  rd_t  [4];
        logic [63:0] imm_t [4];
        ins_t[0] = 32'h002081B3; cls_t[0] = 4'd0; rd_t[0] = 5'd3; imm_t[0] = 64'h0;
        ins_t[1] = 32'hFFF00093; cls_t[1] = 4'd1; rd_t[1] = 5'd1; imm_t[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        ins_t[2] = 32'hFE000EE3; cls_t[2] = 4'd4; rd_t[2] = 5'd0; imm_t[2] = 64'hFFFF_FFFF_FFFF_FFFC;
        ins_t[3] = 32'h123452B7; cls_t[3] = 4'd7; rd_t[3] = 5'd5; imm_t[3] = 64'h0000_0000_1234_5000;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_instr = ins_t[i];
            in_pc    = 64'h8000_0000 + 64'(4 * i);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL dir_latency_early idx=%0d valid=%b want 0", i, out_valid);
            end
            tick();
            in_valid = 1'b0;
            total++;
            if (out_valid !== 1'b1 || out_class !== cls_t[i] || out_rd !== rd_t[i]
                || out_imm !== imm_t[i] || out_illegal !== 1'b0) begin
                bad++;
                $display("FAIL dir_fields idx=%0d valid=%b cls=%0d rd=%0d imm=%h want 1/%0d/%0d/%h",
                         i, out_valid, out_class, out_rd, out_imm, cls_t[i], rd_t[i], imm_t[i]);
            end
            total++;
            if (mq.size() == 0 || obs !== mq[0]) begin
                bad++;
                $display("FAIL dir_model idx=%0d got=%h want=%h", i, obs, mq.size() ? mq[0] : '0);
            end
            tick();
        end
        total++;
        if (out_rs1 !== 5'd0 || out_funct3 !== 3'd0) begin
            bad++;
            $display("FAIL dir_lui_unused rs1=%0d f3=%0d want 0/0", out_rs1, out_funct3);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h0000_0000;
        in_pc     = 64'h40;
        tick();
        in_instr  = 32'h4000_7033;
        in_pc     = 64'h44;
        total++;
        if (out_class !== 4'd15 || out_illegal !== 1'b1 || out_pc !== 64'h40 || out_rd !== 5'd0) begin
            bad++;
            $display("FAIL ill_zero cls=%0d ill=%b pc=%h want 15/1/40", out_class, out_illegal, out_pc);
        end
        tick();
        in_valid = 1'b0;
        total++;
        if (out_class !== 4'd15 || out_illegal !== 1'b1 || out_funct7 !== 7'd0 || out_pc !== 64'h44) begin
            bad++;
            $display("FAIL ill_f7f3 cls=%0d ill=%b f7=%h pc=%h want 15/1/0/44",
                     out_class, out_illegal, out_funct7, out_pc);
        end
        total++;
        if (illegal_count !== 16'd2 || s_illegal_count !== 2'd2) begin
            bad++;
            $display("FAIL ill_count got=%0d sat=%0d want 2/2", illegal_count, s_illegal_count);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_instr = gen_instr();
            in_pc    = 64'h1000 + 64'(4 * i);
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready i=%0d got=%b want 1", i, in_ready);
            end
            if (i > 0) begin
                total++;
                if (out_valid !== 1'b1 || mq.size() == 0 || obs !== mq[0]) begin
                    bad++;
                    $display("FAIL b2b_head i=%0d valid=%b got=%h want=%h", i, out_valid, obs,
                             mq.size() ? mq[0] : '0);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] feed [6];
        rec_t        expv [6];
        int          nin, nout;
        bit          acc;
        for (int k = 0; k < 6; k++) begin
            feed[k] = gen_instr();
            expv[k] = model(feed[k], 64'h2000 + 64'(8 * k));
        end
        nin = 0; nout = 0;
        for (int cyc = 0; cyc < 30 && nout < 6; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (nin < 6);
            in_instr  = (nin < 6) ? feed[nin] : 32'h0;
            in_pc     = 64'h2000 + 64'(8 * nin);
            total++;
            if (in_ready !== (mq.size() < 2)) begin
                bad++;
                $display("FAIL bp_ready cyc=%0d got=%b want=%b", cyc, in_ready, mq.size() < 2);
            end
            if (cyc == 2) begin
                total++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_full ready=%b valid=%b want 0/1", in_ready, out_valid);
                end
            end
            if (cyc >= 1 && cyc <= 3) begin
                total++;
                if (obs !== expv[0]) begin
                    bad++;
                    $display("FAIL bp_hold cyc=%0d got=%h want=%h", cyc, obs, expv[0]);
                end
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                total++;
                if (obs !== expv[nout]) begin
                    bad++;
                    $display("FAIL bp_order n=%0d got=%h want=%h", nout, obs, expv[nout]);
                end
                nout++;
            end
            tick();
            if (acc) nin++;
        end
        in_valid = 1'b0;
        total++;
        if (nout != 6) begin
            bad++;
            $display("FAIL bp_delivered got=%0d want 6", nout);
        end
    endtask

    task automatic test_flush();
        int cnt_before;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h002081B3; in_pc = 64'h3000;
        tick();
        in_instr  = 32'hFFF00093; in_pc = 64'h3004;
        tick();
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_pre valid=%b ready=%b want 1/0", out_valid, in_ready);
        end
        cnt_before = ill_total;
        flush     = 1'b1;
        out_ready = 1'b1;
        in_instr  = 32'h0;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_empty valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
        total++;
        if (illegal_count !== 16'(cnt_before)) begin
            bad++;
            $display("FAIL flush_count got=%0d want=%0d", illegal_count, cnt_before);
        end
        in_valid = 1'b1;
        in_instr = 32'h123452B7; in_pc = 64'h3008;
        tick();
        in_valid = 1'b0;
        total++;
        if (mq.size() != 1 || obs !== mq[0] || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL flush_after got=%h valid=%b", obs, out_valid);
        end
        tick();
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        ill_total = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_instr = 32'($urandom) & 32'hFFFF_FFFC;
            in_pc    = 64'h5000 + 64'(4 * i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (illegal_count !== 16'd5 || s_illegal_count !== 2'd3) begin
            bad++;
            $display("FAIL sat_count got=%0d sat=%0d want 5/3", illegal_count, s_illegal_count);
        end
    endtask

    task automatic test_random();
        int sat;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) < 3);
            in_instr  = gen_instr();
            in_pc     = {32'($urandom), 32'($urandom)};
            sat       = (ill_total > 3) ? 3 : ill_total;
            total++;
            if (in_ready !== (mq.size() < 2) || out_valid !== (mq.size() > 0)) begin
                bad++;
                $display("FAIL rand_hs cyc=%0d ready=%b valid=%b size=%0d", cyc, in_ready, out_valid, mq.size());
            end
            total++;
            if (illegal_count !== 16'(ill_total) || s_illegal_count !== 2'(sat)) begin
                bad++;
                $display("FAIL rand_cnt cyc=%0d got=%0d sat=%0d want=%0d/%0d", cyc,
                         illegal_count, s_illegal_count, ill_total, sat);
            end
            if (mq.size() > 0) begin
                total++;
                if (obs !== mq[0] || s_obs !== mq[0]) begin
                    bad++;
                    $display("FAIL rand_head cyc=%0d got=%h sat=%h want=%h", cyc, obs, s_obs, mq[0]);
                end
            end
            tick();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_instr = gen_instr();
            in_pc    = {32'($urandom), 32'($urandom)} | 64'h4;
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || obs === '0) begin
            bad++;
            $display("FAIL areset_pre valid=%b got=%h", out_valid, obs);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_count !== 16'd0
            || obs !== '0 || s_obs !== '0) begin
            bad++;
            $display("FAIL areset_now valid=%b ready=%b cnt=%0d got=%h want 0/1/0/0",
                     out_valid, in_ready, illegal_count, obs);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        ill_total = 0;
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL areset_after valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = 64'h0;
        test_reset();
        test_directed();
        test_illegal();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_saturation();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
